// File: rtl/arb_mux_reg.sv
// N-input registered bus multiplexer with an internal round-robin or fixed-priority
// arbiter and a one-deep valid/ready output stage.
`ifndef ADDRESS_BUS_WIDTH
`define ADDRESS_BUS_WIDTH 32
`endif

module arb_mux_reg #(
  parameter int WIDTH     = `ADDRESS_BUS_WIDTH,
  parameter int NUM_PORTS = 4,
  parameter int MODE      = 0,
  localparam int SRC_W    = ($clog2(NUM_PORTS) > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PORTS-1:0]       in_valid,
  input  logic [WIDTH*NUM_PORTS-1:0] in_data,
  output logic [NUM_PORTS-1:0]       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [SRC_W-1:0]           out_src,
  input  logic                       out_ready
);

  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] win;
  logic [SRC_W-1:0] next_ptr;
  logic             found;
  logic             accept;
  int unsigned      idx;

  assign accept = !out_valid || out_ready;

  // Scan NUM_PORTS positions starting at the pointer (or at 0 in fixed-priority
  // mode); the first valid port seen wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      idx = k + ((MODE == 1) ? 32'd0 : 32'(rr_ptr));
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && in_valid[SRC_W'(idx)]) begin
        found = 1'b1;
        win   = SRC_W'(idx);
      end
    end
  end

  assign next_ptr = (32'(win) == NUM_PORTS - 1) ? '0 : win + 1'b1;

  always_comb begin
    in_ready = '0;
    if (!reset && accept && found) in_ready[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= in_data[win*WIDTH +: WIDTH];
        out_src   <= win;
        rr_ptr    <= next_ptr;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_reg.sv
// Scoreboard bench for arb_mux_reg: round-robin instance (dut0) and fixed-priority
// instance (dut1), both WIDTH=8, NUM_PORTS=4.
module tb_arb_mux_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_valid, in_ready, valid1, ready1;
  logic [31:0] in_data, data1;
  logic        out_valid, out_ready, ovalid1, oready1;
  logic [7:0]  out_data, odata1;
  logic [1:0]  out_src, osrc1;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic [9:0]  q0[$];
  logic [9:0]  q1[$];

  always #5 clk = ~clk;

  arb_mux_reg #(.WIDTH(8), .NUM_PORTS(4), .MODE(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready));

  arb_mux_reg #(.WIDTH(8), .NUM_PORTS(4), .MODE(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(valid1), .in_data(data1),
    .in_ready(ready1), .out_valid(ovalid1), .out_data(odata1),
    .out_src(osrc1), .out_ready(oready1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Check the grant on dut0 this cycle and queue the word it should produce.
  task automatic g0(input string name, input logic [3:0] rdy, input logic [7:0] d, input logic [1:0] s);
    #1;
    chk(name, 32'(in_ready), 32'(rdy));
    q0.push_back({s, d});
    cyc();
  endtask

  task automatic g1(input string name, input logic [3:0] rdy, input logic [7:0] d, input logic [1:0] s);
    #1;
    chk(name, 32'(ready1), 32'(rdy));
    q1.push_back({s, d});
    cyc();
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (q0.size() == 0) chk("dut0 unexpected output", {22'd0, out_src, out_data}, 32'hFFFF_FFFF);
      else chk("dut0 output {src,data}", {22'd0, out_src, out_data}, 32'(q0.pop_front()));
    end
    if (ovalid1 && oready1) begin
      if (q1.size() == 0) chk("dut1 unexpected output", {22'd0, osrc1, odata1}, 32'hFFFF_FFFF);
      else chk("dut1 output {src,data}", {22'd0, osrc1, odata1}, 32'(q1.pop_front()));
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 4'b1111;
    in_data   = 32'hA3A2A1A0;
    out_ready = 1'b1;
    valid1    = 4'b0000;
    data1     = 32'hA3A2A1A0;
    oready1   = 1'b1;

    // Reset held two cycles with all ports requesting.
    cyc();
    cyc();
    chk("reset in_ready", 32'(in_ready), 32'h0);
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset out_data", 32'(out_data), 32'h0);
    chk("reset out_src", 32'(out_src), 32'h0);
    chk("reset dut1 in_ready", 32'(ready1), 32'h0);

    // Rotation 0,1,2,3,0 then 1,2 so that rr_ptr lands on 3.
    reset = 1'b0;
    g0("rr grant 0", 4'b0001, 8'hA0, 2'd0);
    g0("rr grant 1", 4'b0010, 8'hA1, 2'd1);
    g0("rr grant 2", 4'b0100, 8'hA2, 2'd2);
    g0("rr grant 3", 4'b1000, 8'hA3, 2'd3);
    g0("rr grant 0 again", 4'b0001, 8'hA0, 2'd0);
    g0("rr grant 1 again", 4'b0010, 8'hA1, 2'd1);
    g0("rr grant 2 again", 4'b0100, 8'hA2, 2'd2);

    // Skip and wrap from rr_ptr=3 with ports 0 and 2 requesting.
    in_valid = 4'b0101;
    g0("wrap grant 0", 4'b0001, 8'hA0, 2'd0);
    g0("skip grant 2", 4'b0100, 8'hA2, 2'd2);

    // Backpressure: register holds A2 from port 2.
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall in_ready", 32'(in_ready), 32'h0);
      chk("stall out_data", 32'(out_data), 32'hA2);
      chk("stall out_src", 32'(out_src), 32'h2);
      cyc();
    end
    out_ready = 1'b1;
    g0("grant on release", 4'b1000, 8'hA3, 2'd3);

    // Drain: one word from port 2, then nothing.
    in_valid = 4'b0100;
    in_data  = 32'hA35CA1A0;
    g0("drain grant 2", 4'b0100, 8'h5C, 2'd2);
    in_valid = 4'b0000;
    #1;
    chk("drain in_ready idle", 32'(in_ready), 32'h0);
    chk("drain out_valid high", 32'(out_valid), 32'h1);
    chk("drain out_data", 32'(out_data), 32'h5C);
    cyc();
    chk("drain out_valid low", 32'(out_valid), 32'h0);
    chk("drain out_data held", 32'(out_data), 32'h5C);
    chk("drain out_src held", 32'(out_src), 32'h2);

    // Fixed priority: ports 1..3 requesting, port 1 always wins.
    valid1 = 4'b1110;
    g1("prio grant 1 a", 4'b0010, 8'hA1, 2'd1);
    g1("prio grant 1 b", 4'b0010, 8'hA1, 2'd1);
    chk("prio out_src", 32'(osrc1), 32'h1);
    g1("prio grant 1 c", 4'b0010, 8'hA1, 2'd1);
    chk("prio out_src end", 32'(osrc1), 32'h1);
    valid1 = 4'b0000;
    cyc();
    cyc();
    cyc();

    chk("dut0 scoreboard drained", q0.size(), 32'd0);
    chk("dut1 scoreboard drained", q1.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/arb_mux_reg.md
Name: arb_mux_reg

Overview:
- N-input, registered, handshaked bus multiplexer; parametrised successor of the 4:1 address/data select mux.
- Selection is made internally by a round-robin or fixed-priority arbiter, not by an external select input.
- Output is a one-deep valid/ready register stage.
- Sits in front of the shared address/data bus, where several requesters (fetch, load/store, DMA) contend for one bus port.

Parameters:
- WIDTH, default ADDRESS_BUS_WIDTH (from params.v), bits per data channel.
- NUM_PORTS, default 4, number of requesters; legal range 2..16.
- MODE, default 0; 0 = round-robin arbitration, 1 = fixed priority (lowest index wins).
- SRC_W (localparam), equal to clog2(NUM_PORTS) with a minimum of 1; width of the source index.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  NUM_PORTS  per-port request; bit i belongs to port i.
- in_data  input  WIDTH*NUM_PORTS  port i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NUM_PORTS  one-hot or zero, combinational; bit i high means port i's word is taken this cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered selected word.
- out_src  output  SRC_W  index of the port that supplied out_data.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Reset (synchronous, on a clk edge with reset=1):
  - out_valid=0, out_data=0, out_src=0, round-robin pointer rr_ptr=0.
  - in_ready is forced to 0 while reset=1.
  - Reset mid-transfer discards the held word; no in_ready is asserted in that cycle.
- accept = !out_valid || out_ready. The register may load whenever it is empty or draining in the same cycle; back-to-back throughput is one word per cycle.
- Winner selection, evaluated combinationally each cycle:
  - MODE 0: the first valid port scanning from rr_ptr upward, wrapping NUM_PORTS-1 to 0.
  - MODE 1: the lowest-index valid port; rr_ptr is ignored.
- When accept=1 and any in_valid bit is set:
  - in_ready[w]=1 for winner w only.
  - On the next edge: out_data<=in_data[w], out_src<=w, out_valid<=1, rr_ptr<=(w+1) mod NUM_PORTS.
- When accept=1 and no in_valid bit is set: in_ready=0; on the next edge out_valid<=0. out_data and out_src hold their last values.
- When accept=0 (stalled): in_ready=0; all registers hold; rr_ptr holds.
- Latency: exactly 1 cycle from the in_valid&in_ready transfer to out_valid.
- Requester rules:
  - A requester must hold in_valid and in_data stable until it sees in_ready.
  - The arbiter never grants a port whose in_valid=0.
- Fairness (MODE 0): with all ports continuously valid and out_ready=1, grants cycle 0,1,2,...,N-1,0 with no repeats. No port waits more than NUM_PORTS-1 grants.
- rr_ptr wrap: winner NUM_PORTS-1 sets rr_ptr=0.
- in_ready never depends on in_ready; there is no combinational loop from out_ready back to out_ready.

Test Plan:
1. Reset with WIDTH=8, NUM_PORTS=4, MODE=0: hold reset 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0x00, out_src=0; after release the first grant is port 0.
2. Round-robin rotation: in_valid=1111, data port i=0xA0+i, out_ready=1 -> out_data over consecutive cycles is A0,A1,A2,A3,A0; out_src is 0,1,2,3,0.
3. Skip and wrap: rr_ptr=3, in_valid=0101 -> port 0 is granted (wrap), rr_ptr becomes 1; the next grant is port 2.
4. Backpressure: out_valid=1 and out_ready=0 for 3 cycles with in_valid=1111 -> in_ready=0000, out_data and out_src frozen; when out_ready rises, the next port in rotation is granted in that same cycle.
5. MODE=1 with in_valid=1110 held 3 cycles, out_ready=1 -> port 1 is granted every cycle and out_src=1 throughout.
6. Drain to empty: a single request on port 2 (0x5C), then in_valid=0000 -> out_valid=1 for exactly one cycle with out_data=0x5C, then out_valid=0 while out_data holds 0x5C.
